// File: rtl/pa_fpu_fwb_buf.sv
// pa_fpu_fwb_buf: FGPR write-back buffer between the FPU result bus and the
// FP register-file write port. FPU results are queued in a small circular
// FIFO and drained into the single write port, which is shared with LSU load
// returns. Load returns always own the port. A decode-side lookup reports
// pending buffered writes so decode can forward or stall.
//
// Optional feature macro: PA_FPU_FWB_BYPASS_EN
//   When defined, an FPU result arriving while the buffer is empty and no
//   load owns the port is written straight through in the same cycle and is
//   not enqueued.
//
// Ports:
//   forever_cpuclk         clock, rising edge
//   cpurst_b               asynchronous active-low reset
//   fpu_rtu_fgpr_wb_vld    FPU result valid (only while grant is high)
//   fpu_rtu_fgpr_wb_reg    FPU destination register
//   fpu_rtu_fgpr_wb_data   FPU result data
//   rtu_fpu_fgpr_wb_grant  buffer can accept an FPU result this cycle
//   lsu_rtu_fgpr_wb_vld    load return valid (never stalled)
//   lsu_rtu_fgpr_wb_reg    load destination register
//   lsu_rtu_fgpr_wb_data   load data
//   rtu_fgpr_wen           register-file write enable
//   rtu_fgpr_waddr         register-file write address
//   rtu_fgpr_wdata         register-file write data
//   idu_fwb_chk_reg        decode lookup register
//   fwb_idu_chk_hit        lookup register has a pending buffered write
//   fwb_idu_chk_data       data of the youngest matching entry
//   fwb_buf_empty          no entries held

module pa_fpu_fwb_buf #(
    parameter int unsigned FLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst_b,
    input  logic            fpu_rtu_fgpr_wb_vld,
    input  logic [4:0]      fpu_rtu_fgpr_wb_reg,
    input  logic [FLEN-1:0] fpu_rtu_fgpr_wb_data,
    output logic            rtu_fpu_fgpr_wb_grant,
    input  logic            lsu_rtu_fgpr_wb_vld,
    input  logic [4:0]      lsu_rtu_fgpr_wb_reg,
    input  logic [FLEN-1:0] lsu_rtu_fgpr_wb_data,
    output logic            rtu_fgpr_wen,
    output logic [4:0]      rtu_fgpr_waddr,
    output logic [FLEN-1:0] rtu_fgpr_wdata,
    input  logic [4:0]      idu_fwb_chk_reg,
    output logic            fwb_idu_chk_hit,
    output logic [FLEN-1:0] fwb_idu_chk_data,
    output logic            fwb_buf_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Pointer = {wrap bit, slot index}; the index wraps explicitly so DEPTH
    // need not be a power of two.
    typedef logic [PTR_W:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t r;
        if (p[PTR_W-1:0] == LAST_IDX) begin
            r = {~p[PTR_W], {PTR_W{1'b0}}};
        end else begin
            r = p + ptr_t'(1);
        end
        return r;
    endfunction

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [4:0]       ent_reg_q  [DEPTH];
    logic [4:0]       ent_reg_d  [DEPTH];
    logic [FLEN-1:0]  ent_data_q [DEPTH];
    logic [FLEN-1:0]  ent_data_d [DEPTH];

    logic             grant;
    logic             buf_empty;
    logic             fpu_acc;
    logic             byp;
    logic             enq;
    logic             deq;
    logic [PTR_W-1:0] rd_idx;
    logic [PTR_W-1:0] wr_idx;

    assign rd_idx    = rd_ptr_q[PTR_W-1:0];
    assign wr_idx    = wr_ptr_q[PTR_W-1:0];

    // Grant depends on registered state only.
    assign grant     = (count_q < FULL_CNT);
    assign buf_empty = (count_q == '0);
    assign fpu_acc   = fpu_rtu_fgpr_wb_vld & grant;

`ifdef PA_FPU_FWB_BYPASS_EN
    assign byp = fpu_acc & buf_empty & ~lsu_rtu_fgpr_wb_vld;
`else
    assign byp = 1'b0;
`endif

    assign enq = fpu_acc & ~byp;
    // Head slot is consumed only when the load is not taking the port.
    assign deq = ~lsu_rtu_fgpr_wb_vld & ~buf_empty;

    assign rtu_fpu_fgpr_wb_grant = grant;
    assign fwb_buf_empty         = buf_empty;

    // Next-state for pointers, count and entries.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ent_vld_d  = ent_vld_q;
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;

        // A load is younger than everything already buffered: older buffered
        // writes to the same register are dropped. A same-cycle FPU result is
        // younger than the load, so the enqueue below is applied afterwards.
        if (lsu_rtu_fgpr_wb_vld) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ent_vld_q[i] && (ent_reg_q[i] == lsu_rtu_fgpr_wb_reg)) begin
                    ent_vld_d[i] = 1'b0;
                end
            end
        end

        if (deq) begin
            ent_vld_d[rd_idx] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end

        if (enq) begin
            ent_vld_d[wr_idx]  = 1'b1;
            ent_reg_d[wr_idx]  = fpu_rtu_fgpr_wb_reg;
            ent_data_d[wr_idx] = fpu_rtu_fgpr_wb_data;
            wr_ptr_d           = ptr_inc(wr_ptr_q);
        end

        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ent_vld_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ent_vld_q <= ent_vld_d;
        end
    end

    // Entry payload is qualified by ent_vld_q and needs no reset.
    always_ff @(posedge forever_cpuclk) begin
        ent_reg_q  <= ent_reg_d;
        ent_data_q <= ent_data_d;
    end

    // Register-file write port: load first, then head entry, then bypass.
    always_comb begin
        rtu_fgpr_wen   = 1'b0;
        rtu_fgpr_waddr = 5'd0;
        rtu_fgpr_wdata = '0;
        if (lsu_rtu_fgpr_wb_vld) begin
            rtu_fgpr_wen   = 1'b1;
            rtu_fgpr_waddr = lsu_rtu_fgpr_wb_reg;
            rtu_fgpr_wdata = lsu_rtu_fgpr_wb_data;
        end else if (!buf_empty) begin
            // A killed head is still drained but does not write.
            rtu_fgpr_wen   = ent_vld_q[rd_idx];
            rtu_fgpr_waddr = ent_reg_q[rd_idx];
            rtu_fgpr_wdata = ent_data_q[rd_idx];
        end else if (byp) begin
            rtu_fgpr_wen   = 1'b1;
            rtu_fgpr_waddr = fpu_rtu_fgpr_wb_reg;
            rtu_fgpr_wdata = fpu_rtu_fgpr_wb_data;
        end
    end

    // Lookup walks from the head (oldest) towards the write pointer so the
    // last match seen is the youngest. Same-cycle FPU results are excluded.
    always_comb begin
        int unsigned      j;
        logic [PTR_W-1:0] idx;
        fwb_idu_chk_hit  = 1'b0;
        fwb_idu_chk_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            j = 32'(rd_idx) + k;
            if (j >= DEPTH) begin
                j = j - DEPTH;
            end
            idx = PTR_W'(j);
            if (ent_vld_q[idx] && (ent_reg_q[idx] == idu_fwb_chk_reg)) begin
                fwb_idu_chk_hit  = 1'b1;
                fwb_idu_chk_data = ent_data_q[idx];
            end
        end
    end

endmodule
